// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and register-file constants plus opcode decode helpers
// shared by the register_op_arbiter front end and the core CPU.
package cpu_pkg;
   localparam int OP_W = 3;
   localparam int NUM_REGS = 3;
   localparam logic [1:0] REG_SEL_NOP = 2'b00;
   localparam logic OP_INC = 1'b1;
   localparam logic OP_CLR = 1'b0;

   typedef struct packed {
      logic       nop;
      logic [1:0] idx;
      logic       inc;
   } dec_op_t;

   // Register selects 01/10/11 map to index 0/1/2; no-ops park on index 0.
   function automatic logic [1:0] op_to_reg_idx(input logic [OP_W-1:0] op);
      return (op[2:1] == REG_SEL_NOP) ? 2'd0 : op[2:1] - 2'd1;
   endfunction

   function automatic dec_op_t decode_op(input logic [OP_W-1:0] op);
      decode_op.nop = (op[2:1] == REG_SEL_NOP);
      decode_op.idx = op_to_reg_idx(op);
      decode_op.inc = (op[0] == OP_INC);
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the search begins at ptr and
// wraps, returning a one-hot grant and its index.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);
   always_comb begin
      int j;
      logic found;
      grant = '0;
      grant_idx = '0;
      found = 1'b0;
      j = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!found && req[j]) begin
            found = 1'b1;
            grant[j] = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end
endmodule

// File: rtl/register_op_arbiter.sv
// register_op_arbiter: round-robin shares a 3-register inc/clear datapath
// among NUM_REQ sources through a decode/execute pipeline with completion pulses.
module register_op_arbiter
   import cpu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int REG_WIDTH = 32,
   parameter int CNT_WIDTH = 16,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [OP_W*NUM_REQ-1:0]       req_op,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [REG_WIDTH-1:0]          rsp_data,
   output logic [NUM_REGS*REG_WIDTH-1:0] reg_out,
   output logic [IW-1:0]                 grant_id,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          op_count
);
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0] grant_idx;
   logic accept;
   logic [OP_W-1:0] win_op;
   logic [REG_WIDTH-1:0] new_val;
   logic [IW-1:0] ptr_q, ptr_d, grant_id_q, grant_id_d, dec_owner_q, dec_owner_d;
   logic dec_valid_q, dec_valid_d, exe_valid_q, exe_valid_d;
   dec_op_t dec_op_q, dec_op_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [REG_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [NUM_REGS-1:0][REG_WIDTH-1:0] reg_q, reg_d;
   logic [CNT_WIDTH-1:0] op_count_q, op_count_d;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Ready is gated by reset so nothing appears accepted while in reset.
   assign req_ready = grant & {NUM_REQ{reset}};
   assign accept = |req_ready;
   assign win_op = req_op[int'(grant_idx)*OP_W +: OP_W];

   always_comb begin
      ptr_d = accept ? ((grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1) : ptr_q;
      grant_id_d = accept ? grant_idx : grant_id_q;
      dec_valid_d = accept;
      dec_owner_d = accept ? grant_idx : dec_owner_q;
      dec_op_d = accept ? decode_op(win_op) : dec_op_q;
   end

   // Execute reads reg_q directly, so back-to-back ops see the prior write.
   always_comb begin
      new_val = (dec_op_q.inc == OP_CLR) ? '0 : reg_q[dec_op_q.idx] + 1'b1;
      reg_d = reg_q;
      if (dec_valid_q && !dec_op_q.nop) reg_d[dec_op_q.idx] = new_val;
      exe_valid_d = dec_valid_q;
      rsp_valid_d = dec_valid_q ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << dec_owner_q) : '0;
      rsp_data_d = dec_valid_q ? (dec_op_q.nop ? '0 : new_val) : rsp_data_q;
      op_count_d = (dec_valid_q && !dec_op_q.nop && !(&op_count_q)) ? op_count_q + 1'b1 : op_count_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
         grant_id_q <= '0;
         dec_valid_q <= 1'b0;
         dec_owner_q <= '0;
         dec_op_q <= '0;
         exe_valid_q <= 1'b0;
         rsp_valid_q <= '0;
         rsp_data_q <= '0;
         reg_q <= '0;
         op_count_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         grant_id_q <= grant_id_d;
         dec_valid_q <= dec_valid_d;
         dec_owner_q <= dec_owner_d;
         dec_op_q <= dec_op_d;
         exe_valid_q <= exe_valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q <= rsp_data_d;
         reg_q <= reg_d;
         op_count_q <= op_count_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data = rsp_data_q;
   assign reg_out = reg_q;
   assign grant_id = grant_id_q;
   assign busy = dec_valid_q | exe_valid_q;
   assign op_count = op_count_q;
endmodule

// File: tb/tb_register_op_arbiter.sv
// tb_register_op_arbiter: directed vectors with hand-computed expectations
// for arbitration order, pipeline timing, wrap, saturation and reset.
module tb_register_op_arbiter;
   logic        clock;
   logic        reset;
   logic [3:0]  req_valid;
   logic [11:0] req_op;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic [95:0] reg_out;
   logic [1:0]  grant_id;
   logic        busy;
   logic [15:0] op_count;
   int checks = 0;
   int errors = 0;

   register_op_arbiter #(.NUM_REQ(4), .REG_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .reg_out   (reg_out),
      .grant_id  (grant_id),
      .busy      (busy),
      .op_count  (op_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_valid = '0;
      step();
      reset = 1'b1;
      #1;
   endtask

   logic [2:0] t4_ops [3] = '{3'b111, 3'b110, 3'b001};
   int         t4_exp [3] = '{1, 0, 0};

   initial begin
      reset = 1'b0;
      req_valid = 4'hF;
      req_op = '0;
      repeat (3) step();
      check("rst_ready", req_ready, 4'b0000);
      check("rst_regs", reg_out, 96'd0);
      check("rst_count", op_count, 16'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_rsp", rsp_valid, 4'b0000);
      reset = 1'b1;
      #1;
      check("rel_ready", req_ready, 4'b0001);
      req_valid = 4'b0001;
      step();
      check("rel_gid", grant_id, 2'd0);
      check("rel_busy", busy, 1'b1);
      req_valid = '0;
      step();
      check("nop0_vld", rsp_valid, 4'b0001);
      check("nop0_data", rsp_data, 32'd0);
      check("nop0_count", op_count, 16'd0);
      step();
      check("nop0_idle", busy, 1'b0);

      // requester 1 streams three inc reg0 ops
      for (int i = 0; i < 5; i++) begin
         req_valid = (i < 3) ? 4'b0010 : 4'b0000;
         req_op[5:3] = 3'b011;
         #1;
         if (i < 3) check("t2_ready", req_ready, 4'b0010);
         if (i >= 2) begin
            check("t2_vld", rsp_valid, 4'b0010);
            check("t2_data", rsp_data, 32'(i - 1));
         end
         step();
      end
      check("t2_vld_end", rsp_valid, 4'b0000);
      check("t2_count", op_count, 16'd3);
      check("t2_reg0", reg_out[31:0], 32'd3);
      check("t2_gid", grant_id, 2'd1);

      // all four requesters contend with inc reg1
      do_reset();
      req_op = {4{3'b101}};
      for (int i = 0; i < 7; i++) begin
         req_valid = (i < 5) ? 4'hF : 4'h0;
         #1;
         check("t3_ready", req_ready, (i < 5) ? (4'b0001 << (i % 4)) : 4'b0000);
         if (i >= 2) begin
            check("t3_vld", rsp_valid, 4'b0001 << ((i - 2) % 4));
            check("t3_data", rsp_data, 32'(i - 1));
         end
         step();
      end
      check("t3_reg1", reg_out[63:32], 32'd5);
      check("t3_count", op_count, 16'd5);
      check("t3_gid", grant_id, 2'd0);

      // requester 2: inc reg2, clear reg2, no-op
      req_op = '0;
      for (int i = 0; i < 5; i++) begin
         req_valid = (i < 3) ? 4'b0100 : 4'b0000;
         if (i < 3) req_op[8:6] = t4_ops[i];
         #1;
         if (i >= 2) begin
            check("t4_vld", rsp_valid, 4'b0100);
            check("t4_data", rsp_data, 32'(t4_exp[i - 2]));
         end
         if (i >= 3) check("t4_count", op_count, 16'd7);
         step();
      end
      check("t4_regs", reg_out, {32'd0, 32'd5, 32'd0});
      check("t4_count_end", op_count, 16'd7);

      // register wrap from a forced all-ones value
      force dut.reg_q = {32'd0, 32'd5, 32'hFFFF_FFFF};
      step();
      release dut.reg_q;
      #1;
      check("t5_preload", reg_out[31:0], 32'hFFFF_FFFF);
      req_valid = 4'b0001;
      req_op = {9'd0, 3'b011};
      step();
      req_valid = '0;
      step();
      check("t5_wrap_vld", rsp_valid, 4'b0001);
      check("t5_wrap_data", rsp_data, 32'd0);
      check("t5_wrap_reg", reg_out, {32'd0, 32'd5, 32'd0});
      check("t5_wrap_count", op_count, 16'd8);

      // counter saturation from a forced near-max value
      force dut.op_count_q = 16'hFFFE;
      step();
      release dut.op_count_q;
      for (int i = 0; i < 4; i++) begin
         req_valid = (i < 2) ? 4'b0001 : 4'b0000;
         #1;
         if (i >= 2) begin
            check("t5_sat", op_count, 16'hFFFF);
            check("t5_sat_data", rsp_data, 32'(i - 1));
         end
         step();
      end

      // reset one cycle after an accept drops the in-flight op
      req_valid = 4'b0010;
      req_op = {6'd0, 3'b101, 3'd0};
      step();
      req_valid = 4'hF;
      reset = 1'b0;
      #1;
      check("t6_regs", reg_out, 96'd0);
      check("t6_busy", busy, 1'b0);
      check("t6_rsp", rsp_valid, 4'b0000);
      check("t6_ready", req_ready, 4'b0000);
      step();
      check("t6_rsp_hold", rsp_valid, 4'b0000);
      req_valid = '0;
      reset = 1'b1;
      step();
      step();
      check("t6_rsp_after", rsp_valid, 4'b0000);
      check("t6_count", op_count, 16'd0);
      check("t6_regs_after", reg_out, 96'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
